// File: rtl/decode_pipe.sv
// decode_pipe: MIPS instruction-decode pipeline stage.
//
// Accepts a fetched instruction and its PC over a valid/ready handshake and
// splits the word into register fields. It classifies the format (R/I/J),
// builds the extended immediate, the branch and jump targets and the
// write-back destination, then registers all of it for register-read/execute.
// The stage holds one instruction, stalls under backpressure, supports flush,
// and sustains one instruction per cycle.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   upstream handshake; in_instr, in_pc carry the payload
//   flush               kill the instruction held or entering this cycle
//   out_valid/out_ready downstream handshake
//   opcode, rs, rt, rd, shamt, func   raw instruction fields
//   imm_ext             extended immediate (zero, LUI-shifted or sign)
//   fmt                 0 = R, 1 = I, 2 = J
//   dest, dest_we       write-back register index and its write enable
//   br_target, j_target branch and jump targets
//   out_pc              PC of the registered instruction

module decode_pipe #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned RA_REG = 31
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [5:0]      opcode,
    output logic [4:0]      rs,
    output logic [4:0]      rt,
    output logic [4:0]      rd,
    output logic [4:0]      shamt,
    output logic [5:0]      func,
    output logic [XLEN-1:0] imm_ext,
    output logic [1:0]      fmt,
    output logic [4:0]      dest,
    output logic            dest_we,
    output logic [XLEN-1:0] br_target,
    output logic [XLEN-1:0] j_target,
    output logic [XLEN-1:0] out_pc
);

    localparam logic [5:0] OpRType = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpJal   = 6'h03;
    localparam logic [5:0] OpAndi  = 6'h0C;
    localparam logic [5:0] OpOri   = 6'h0D;
    localparam logic [5:0] OpXori  = 6'h0E;
    localparam logic [5:0] OpLui   = 6'h0F;
    localparam logic [5:0] FuncJr  = 6'h08;

    localparam logic [1:0] FmtR = 2'd0;
    localparam logic [1:0] FmtI = 2'd1;
    localparam logic [1:0] FmtJ = 2'd2;

    // Registered state
    logic            valid_q, valid_d;
    logic [31:0]     instr_q;
    logic [XLEN-1:0] imm_q, imm_d;
    logic [1:0]      fmt_q, fmt_d;
    logic [4:0]      dest_q, dest_d;
    logic            dest_we_q, dest_we_d;
    logic [XLEN-1:0] br_q, br_d;
    logic [XLEN-1:0] j_q, j_d;
    logic [XLEN-1:0] pc_q;

    logic            accept;

    // Decode scratch
    logic [5:0]      in_op;
    logic [5:0]      in_func;
    logic [4:0]      in_rt;
    logic [4:0]      in_rd;
    logic [15:0]     in_imm;
    logic [XLEN-1:0] imm_sext;
    logic [XLEN-1:0] pc_plus4;

    // in_ready deliberately ignores flush so the upstream sees a plain handshake.
    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    assign in_op    = in_instr[31:26];
    assign in_rt    = in_instr[20:16];
    assign in_rd    = in_instr[15:11];
    assign in_func  = in_instr[5:0];
    assign in_imm   = in_instr[15:0];
    assign imm_sext = {{(XLEN-16){in_imm[15]}}, in_imm};
    assign pc_plus4 = in_pc + XLEN'(4);

    // Format, destination and write enable
    always_comb begin
        fmt_d     = FmtI;
        dest_d    = in_rt;
        dest_we_d = 1'b0;
        if (in_op == OpRType) begin
            fmt_d     = FmtR;
            dest_d    = in_rd;
            dest_we_d = (in_func != FuncJr);
        end else if (in_op == OpJ) begin
            fmt_d     = FmtJ;
            dest_d    = 5'd0;
            dest_we_d = 1'b0;
        end else if (in_op == OpJal) begin
            fmt_d     = FmtJ;
            dest_d    = 5'(RA_REG);
            dest_we_d = 1'b1;
        end else begin
            // ALU-immediate 0x08..0x0F and loads 0x20..0x25 write rt; stores,
            // branches and unknown opcodes do not.
            fmt_d     = FmtI;
            dest_d    = in_rt;
            dest_we_d = ((in_op >= 6'h08) && (in_op <= 6'h0F)) ||
                        ((in_op >= 6'h20) && (in_op <= 6'h25));
        end
        // $0 is hardwired; never report a write to it.
        if (dest_d == 5'd0) begin
            dest_we_d = 1'b0;
        end
    end

    // Immediate extension
    always_comb begin
        imm_d = imm_sext;
        if ((in_op == OpAndi) || (in_op == OpOri) || (in_op == OpXori)) begin
            imm_d        = '0;
            imm_d[15:0]  = in_imm;
        end else if (in_op == OpLui) begin
            imm_d        = '0;
            imm_d[31:16] = in_imm;
        end
    end

    // Targets are computed ahead of the register so they cost no extra cycle.
    always_comb begin
        br_d        = pc_plus4 + (imm_sext << 2);
        j_d         = pc_plus4;
        j_d[27:0]   = {in_instr[25:0], 2'b00};
    end

    // Flush wins over accept; an accepted-and-flushed word is consumed and lost.
    always_comb begin
        valid_d = valid_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q   <= 1'b0;
            instr_q   <= '0;
            imm_q     <= '0;
            fmt_q     <= '0;
            dest_q    <= '0;
            dest_we_q <= 1'b0;
            br_q      <= '0;
            j_q       <= '0;
            pc_q      <= '0;
        end else begin
            valid_q <= valid_d;
            if (accept) begin
                instr_q   <= in_instr;
                imm_q     <= imm_d;
                fmt_q     <= fmt_d;
                dest_q    <= dest_d;
                dest_we_q <= dest_we_d;
                br_q      <= br_d;
                j_q       <= j_d;
                pc_q      <= in_pc;
            end
        end
    end

    assign out_valid = valid_q;
    assign opcode    = instr_q[31:26];
    assign rs        = instr_q[25:21];
    assign rt        = instr_q[20:16];
    assign rd        = instr_q[15:11];
    assign shamt     = instr_q[10:6];
    assign func      = instr_q[5:0];
    assign imm_ext   = imm_q;
    assign fmt       = fmt_q;
    assign dest      = dest_q;
    assign dest_we   = dest_we_q;
    assign br_target = br_q;
    assign j_target  = j_q;
    assign out_pc    = pc_q;

endmodule

// File: tb/tb_decode_pipe.sv
// Self-checking bench for decode_pipe: directed steps from the test plan
// followed by a randomized handshake stream checked against a reference model.

module tb_decode_pipe;

    localparam int unsigned XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [5:0]      opcode;
    logic [4:0]      rs, rt, rd, shamt;
    logic [5:0]      func;
    logic [XLEN-1:0] imm_ext;
    logic [1:0]      fmt;
    logic [4:0]      dest;
    logic            dest_we;
    logic [XLEN-1:0] br_target, j_target, out_pc;

    decode_pipe #(.XLEN(XLEN), .RA_REG(31)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .opcode    (opcode),
        .rs        (rs),
        .rt        (rt),
        .rd        (rd),
        .shamt     (shamt),
        .func      (func),
        .imm_ext   (imm_ext),
        .fmt       (fmt),
        .dest      (dest),
        .dest_we   (dest_we),
        .br_target (br_target),
        .j_target  (j_target),
        .out_pc    (out_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned op, rs, rt, rd, sh, fn;
        int unsigned imm, fmt, dest, we, br, jt, pc;
    } exp_t;

    int unsigned pass_cnt = 0;
    int unsigned total    = 0;
    bit          mvalid   = 0;
    exp_t        m;
    logic [4:0]  held_rs;
    logic [31:0] held_pc;

    // Reference decode written from the instruction-set rules.
    function automatic exp_t model(input int unsigned ins, input int unsigned pc);
        exp_t e;
        int unsigned imm16, simm, pc4;
        e.op  = ins >> 26;
        e.rs  = (ins >> 21) & 31;
        e.rt  = (ins >> 16) & 31;
        e.rd  = (ins >> 11) & 31;
        e.sh  = (ins >> 6) & 31;
        e.fn  = ins & 63;
        e.pc  = pc;
        imm16 = ins & 16'hFFFF;
        simm  = (imm16 >= 32768) ? (imm16 + 32'hFFFF_0000) : imm16;
        if (e.op == 12 || e.op == 13 || e.op == 14) e.imm = imm16;
        else if (e.op == 15)                        e.imm = imm16 * 65536;
        else                                        e.imm = simm;
        pc4  = pc + 4;
        e.br = pc4 + simm * 4;
        e.jt = (pc4 & 32'hF000_0000) + (ins & 32'h03FF_FFFF) * 4;
        if (e.op == 0) begin
            e.fmt = 0; e.dest = e.rd; e.we = (e.fn != 8) ? 1 : 0;
        end else if (e.op == 2) begin
            e.fmt = 2; e.dest = 0; e.we = 0;
        end else if (e.op == 3) begin
            e.fmt = 2; e.dest = 31; e.we = 1;
        end else begin
            e.fmt  = 1;
            e.dest = e.rt;
            e.we   = ((e.op >= 8 && e.op <= 15) || (e.op >= 32 && e.op <= 37)) ? 1 : 0;
        end
        if (e.dest == 0) e.we = 0;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic check_outputs();
        chk("out_valid", 32'(out_valid), 32'(mvalid));
        if (mvalid) begin
            chk("opcode", 32'(opcode), m.op);
            chk("rs", 32'(rs), m.rs);
            chk("rt", 32'(rt), m.rt);
            chk("rd", 32'(rd), m.rd);
            chk("shamt", 32'(shamt), m.sh);
            chk("func", 32'(func), m.fn);
            chk("imm_ext", imm_ext, m.imm);
            chk("fmt", 32'(fmt), m.fmt);
            chk("dest", 32'(dest), m.dest);
            chk("dest_we", 32'(dest_we), m.we);
            chk("br_target", br_target, m.br);
            chk("j_target", j_target, m.jt);
            chk("out_pc", out_pc, m.pc);
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 0);
        chk({tag, "_ready"}, 32'(in_ready), 1);
        chk({tag, "_instr"}, {opcode, rs, rt, rd, shamt, func}, 0);
        chk({tag, "_imm"}, imm_ext, 0);
        chk({tag, "_fmt_dest"}, {fmt, dest, dest_we}, 0);
        chk({tag, "_br"}, br_target, 0);
        chk({tag, "_jt"}, j_target, 0);
        chk({tag, "_pc"}, out_pc, 0);
    endtask

    // One clock of stimulus; called at posedge+1, returns at next posedge+1.
    task automatic cyc(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic fl, input logic ordy);
        bit acc;
        in_valid  = v;
        in_instr  = ins;
        in_pc     = pc;
        flush     = fl;
        out_ready = ordy;
        #1;
        chk("in_ready", 32'(in_ready), 32'(!mvalid || ordy));
        acc = v && (!mvalid || ordy);
        if (acc) m = model(ins, pc);
        if (fl)        mvalid = 0;
        else if (acc)  mvalid = 1;
        else if (ordy) mvalid = 0;
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_pc     = '0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst = 1'b0;

        // Directed decode examples
        cyc(1, 32'h2230_FFFC, 32'h0040_0000, 0, 1);
        chk("addi_op", 32'(opcode), 32'h08);
        chk("addi_rs", 32'(rs), 17);
        chk("addi_rt", 32'(rt), 16);
        chk("addi_imm", imm_ext, 32'hFFFF_FFFC);
        chk("addi_fmt", 32'(fmt), 1);
        chk("addi_dest", {dest, dest_we}, {5'd16, 1'b1});
        cyc(1, 32'h3442_8000, 32'h0040_0004, 0, 1);
        chk("ori_imm", imm_ext, 32'h0000_8000);
        cyc(1, 32'h3C01_1234, 32'h0040_0008, 0, 1);
        chk("lui_imm", imm_ext, 32'h1234_0000);
        cyc(1, 32'h1000_FFFF, 32'h0040_0010, 0, 1);
        chk("beq_br", br_target, 32'h0040_0010);
        chk("beq_we", 32'(dest_we), 0);
        cyc(1, 32'h0C10_0004, 32'h0040_0000, 0, 1);
        chk("jal_fmt", 32'(fmt), 2);
        chk("jal_jt", j_target, 32'h0040_0010);
        chk("jal_dest", {dest, dest_we}, {5'd31, 1'b1});
        cyc(1, 32'h0109_5020, 32'h0040_0014, 0, 1);
        chk("add_rd", 32'(rd), 10);
        chk("add_func", 32'(func), 32'h20);
        chk("add_dest", {dest, dest_we}, {5'd10, 1'b1});
        cyc(1, 32'h0109_0020, 32'h0040_0018, 0, 1);
        chk("r0_we", 32'(dest_we), 0);
        cyc(1, 32'h03E0_0008, 32'h0040_001C, 0, 1);
        chk("jr_we", 32'(dest_we), 0);

        // Backpressure: JR is held while a new word waits upstream.
        held_rs = rs;
        held_pc = out_pc;
        for (int i = 0; i < 3; i++) begin
            cyc(1, 32'h2108_0001, 32'h0040_0020, 0, 0);
            chk("stall_ready", 32'(in_ready), 0);
            chk("stall_rs", 32'(rs), 32'(held_rs));
            chk("stall_pc", out_pc, held_pc);
        end
        cyc(1, 32'h2108_0001, 32'h0040_0020, 0, 1);
        chk("release_pc", out_pc, 32'h0040_0020);

        // Flush of an entering instruction
        cyc(1, 32'h2129_0002, 32'h0040_0024, 1, 1);
        chk("flush_in_valid", 32'(out_valid), 0);
        // Flush while stalled drops the held instruction
        cyc(1, 32'h214A_0003, 32'h0040_0028, 0, 1);
        cyc(1, 32'h216B_0004, 32'h0040_002C, 1, 0);
        chk("flush_stall_valid", 32'(out_valid), 0);
        chk("flush_stall_ready", 32'(in_ready), 1);

        // Randomized stream
        for (int i = 0; i < 400; i++) begin
            logic [31:0] ins;
            logic [5:0]  ops [10] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h08,
                                     6'h0C, 6'h0F, 6'h23, 6'h2B, 6'h3F};
            ins = $urandom;
            if ($urandom_range(0, 3) != 0) ins[31:26] = ops[$urandom_range(0, 9)];
            if (ins[31:26] == 6'h00 && $urandom_range(0, 4) == 0) ins[5:0] = 6'h08;
            cyc(($urandom_range(0, 3) != 0), ins, $urandom,
                ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 7));
        end

        // Asynchronous reset while an instruction is held
        cyc(1, 32'h2230_FFFC, 32'h0040_0100, 0, 1);
        cyc(0, 32'h0, 32'h0, 0, 0);
        chk("pre_rst_valid", 32'(out_valid), 1);
        #1;
        rst = 1'b1;
        #1;
        check_reset_state("async_rst");
        mvalid = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(1, 32'h3442_8000, 32'h0040_0104, 0, 1);
        chk("post_rst_imm", imm_ext, 32'h0000_8000);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
